irq_timer_controller: RTL

//  Parametrised interrupt and timer controller for the 68000 system controller.

---
 rtl/irq_timer_controller_if.sv | 23 ++
 rtl/irq_timer_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_controller_if.sv
// CPU-side bus of the interrupt/timer controller: register window and IACK handshake.
interface irq_timer_controller_if;
    logic       CS_n;
    logic       AS_n;
    logic       RW;
    logic       LDS_n;
    logic [2:0] FC;
    logic [3:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DTACK_n;
    logic       VPA_n;

    modport master (
        output CS_n, AS_n, RW, LDS_n, FC, ADDR, DATA_IN,
        input  DATA_OUT, DTACK_n, VPA_n
    );

    modport slave (
        input  CS_n, AS_n, RW, LDS_n, FC, ADDR, DATA_IN,
        output DATA_OUT, DTACK_n, VPA_n
    );
endinterface

// File: rtl/irq_timer_controller.sv
// Programmable periodic timers, 7-level IPL priority encoder, autovector
// generation and a byte-wide register file for the 68000 system controller.
module irq_timer_controller #(
    parameter int unsigned NUM_TIMERS     = 4,
    parameter int unsigned TIMER_WIDTH    = 24,
    parameter int unsigned DEFAULT_RELOAD = 400000,
    parameter int unsigned TIMER_LEVEL    = 6,
    parameter logic [7:0]  VECTORED_MASK  = 8'h20,
    parameter bit          AUTO_CLEAR     = 1'b1
) (
    input  logic                   CLK_CPU,
    input  logic                   RST_n,
    irq_timer_controller_if.slave  bus,
    input  logic [6:0]             IRQ_n,
    output logic [2:0]             IPL_n
);
    localparam int unsigned NT = NUM_TIMERS;
    localparam int unsigned TW = TIMER_WIDTH;

    typedef enum logic {ST_IDLE, ST_ACK} bus_state_t;

    bus_state_t     state;
    logic [6:0]     irq_s1;
    logic [6:0]     irq_s2;
    logic [7:1]     mask;
    logic [NT-1:0]  status;
    logic [NT-1:0]  enable;
    logic [NT-1:0]  enable_q;
    logic [TW-1:0]  reload     [NT];
    logic [TW-1:0]  count      [NT];
    logic [TW-1:0]  reload_nxt [NT];
    logic [23:0]    reload_ext [NT];
    logic [23:0]    wr_ext     [NT];
    logic [NT-1:0]  expire;
    logic [NT-1:0]  clear;
    logic [NT-1:0]  status_nxt;
    logic [7:1]     active;
    logic [2:0]     top_level;
    logic [7:0]     rd_data;
    logic           reg_sel;
    logic           iack_sel;
    logic           wr_en;
    logic           iack_clear;

    // Bus cycle qualification; writes and IACK side effects happen only on the IDLE->ACK edge
    assign reg_sel    = ~bus.AS_n & ~bus.CS_n & (bus.FC != 3'b111);
    assign iack_sel   = ~bus.AS_n & (bus.FC == 3'b111) & ~VECTORED_MASK[bus.ADDR[3:1]];
    assign wr_en      = (state == ST_IDLE) & reg_sel & ~bus.RW & ~bus.LDS_n;
    assign iack_clear = (state == ST_IDLE) & iack_sel & AUTO_CLEAR
                        & (bus.ADDR[3:1] == 3'(TIMER_LEVEL));

    // Active levels: synchronised request or pending timer, gated by mask (level 7 unmaskable)
    always_comb begin
        active = '0;
        for (int unsigned l = 1; l <= 7; l++) begin
            active[l] = (~irq_s2[l-1] | ((l == TIMER_LEVEL) & (|status)))
                        & (mask[l] | (l == 7));
        end
    end

    // Highest active level wins
    always_comb begin
        top_level = 3'd0;
        for (int unsigned l = 1; l <= 7; l++) begin
            if (active[l]) top_level = 3'(l);
        end
    end

    // Reload registers viewed as 24-bit byte lanes; unimplemented upper bits read 0
    always_comb begin
        for (int unsigned n = 0; n < NT; n++) begin
            reload_ext[n] = 24'(reload[n]);
        end
    end

    // Byte write into a reload register; bits above TIMER_WIDTH are dropped
    always_comb begin
        for (int unsigned n = 0; n < NT; n++) begin
            wr_ext[n] = reload_ext[n];
            for (int unsigned b = 0; b < 3; b++) begin
                if (wr_en && (32'(bus.ADDR) == 4 + 3*n + b)) wr_ext[n][8*b +: 8] = bus.DATA_IN;
            end
            reload_nxt[n] = TW'(wr_ext[n]);
        end
    end

    // Register read mux
    always_comb begin
        rd_data = 8'h00;
        case (bus.ADDR)
            4'd0: rd_data = {mask, 1'b0};
            4'd1: rd_data = {active, 1'b0};
            4'd2: rd_data = 8'(status);
            4'd3: rd_data = 8'(enable);
            default: begin
                for (int unsigned n = 0; n < NT; n++) begin
                    for (int unsigned b = 0; b < 3; b++) begin
                        if (32'(bus.ADDR) == 4 + 3*n + b) rd_data = reload_ext[n][8*b +: 8];
                    end
                end
            end
        endcase
    end

    // Status flags: expiry sets, w1c or autovector IACK clears, set wins a collision
    always_comb begin
        clear = '0;
        if (wr_en && (bus.ADDR == 4'd2)) clear = bus.DATA_IN[NT-1:0];
        if (iack_clear) clear = '1;
        for (int unsigned n = 0; n < NT; n++) begin
            expire[n] = enable[n] & enable_q[n] & (count[n] == TW'(1));
        end
        status_nxt = (status & ~clear) | expire;
    end

    // Interrupt sync, IPL register, control registers and timer counters
    always_ff @(posedge CLK_CPU) begin
        if (!RST_n) begin
            irq_s1   <= 7'h7F;
            irq_s2   <= 7'h7F;
            IPL_n    <= 3'b111;
            mask     <= 7'h7F;
            status   <= '0;
            enable   <= '0;
            enable_q <= '0;
            for (int unsigned n = 0; n < NT; n++) begin
                count[n]  <= '0;
                reload[n] <= (n == 0) ? TW'(DEFAULT_RELOAD) : '0;
            end
        end else begin
            irq_s1   <= IRQ_n;
            irq_s2   <= irq_s1;
            IPL_n    <= ~top_level;
            enable_q <= enable;
            status   <= status_nxt;
            if (wr_en && (bus.ADDR == 4'd0)) mask   <= bus.DATA_IN[7:1];
            if (wr_en && (bus.ADDR == 4'd3)) enable <= bus.DATA_IN[NT-1:0];
            for (int unsigned n = 0; n < NT; n++) begin
                reload[n] <= reload_nxt[n];
                if (enable[n] && !enable_q[n]) begin
                    count[n] <= reload[n];
                end else if (enable[n] && (count[n] != '0)) begin
                    count[n] <= (count[n] == TW'(1)) ? reload[n] : count[n] - TW'(1);
                end
            end
        end
    end

    // Bus FSM: one acknowledge (DTACK_n or VPA_n) per address strobe
    always_ff @(posedge CLK_CPU) begin
        if (!RST_n) begin
            state        <= ST_IDLE;
            bus.DTACK_n  <= 1'b1;
            bus.VPA_n    <= 1'b1;
            bus.DATA_OUT <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iack_sel) begin
                        state     <= ST_ACK;
                        bus.VPA_n <= 1'b0;
                    end else if (reg_sel) begin
                        state        <= ST_ACK;
                        bus.DTACK_n  <= 1'b0;
                        bus.DATA_OUT <= (bus.RW && !bus.LDS_n) ? rd_data : 8'h00;
                    end
                end
                ST_ACK: begin
                    if (bus.AS_n) begin
                        state        <= ST_IDLE;
                        bus.DTACK_n  <= 1'b1;
                        bus.VPA_n    <= 1'b1;
                        bus.DATA_OUT <= 8'h00;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
